muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide engine in the EX stage, beside the single-cycle ALU. It covers the eight M-extension R3 ops that the ALU does not implement: opcode OP_R3 with funct_7 = 0000001.
- Runs a shift-add multiply or a restoring divide over 32 iterations. While it runs it holds the pipeline with stall; the result goes onto the EX writeback path in DONE.

---
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply and restoring divide,
// one step per cycle, holding the pipeline with stall until the result is ready.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct_3,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST = CW'(XLEN-1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       counter;
    logic [2:0]          op;
    logic                neg;
    logic [XLEN-1:0]     opnd;
    logic [2*XLEN-1:0]   acc;

    logic                sgn1, sgn2, neg1, neg2, res_neg;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div_zero, ovf, special;
    logic [XLEN-1:0]     special_val;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, div_next, acc_neg;
    logic [XLEN:0]       div_shift;
    logic [XLEN+1:0]     div_trial;
    logic [XLEN-1:0]     quot_fix, rem_fix, fix_val;

    // Operand decode: signed views, magnitudes, result sign and no-iteration cases
    always_comb begin
        sgn1     = (funct_3 == 3'b001) || (funct_3 == 3'b010) ||
                   (funct_3 == 3'b100) || (funct_3 == 3'b110);
        sgn2     = (funct_3 == 3'b001) || (funct_3 == 3'b100) || (funct_3 == 3'b110);
        neg1     = sgn1 & in1[XLEN-1];
        neg2     = sgn2 & in2[XLEN-1];
        mag1     = neg1 ? (~in1 + ONE) : in1;
        mag2     = neg2 ? (~in2 + ONE) : in2;
        // Remainder follows the dividend; every other signed op uses the xor of signs.
        res_neg  = (funct_3 == 3'b110) ? neg1 : (neg1 ^ neg2);
        div_zero = funct_3[2] && (in2 == ZERO);
        ovf      = funct_3[2] && !funct_3[0] && (in1 == MINV) && (in2 == ONES);
        special  = div_zero || ovf;
        if (div_zero) begin
            special_val = funct_3[1] ? in1 : ONES;
        end else begin
            special_val = funct_3[1] ? ZERO : MINV;
        end
    end

    // One iteration step for each algorithm, plus sign-corrected outputs for FIX
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_trial = {1'b0, div_shift} - {2'b00, opnd};
        if (div_trial[XLEN+1]) begin
            div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
        acc_neg  = neg ? (~acc + {{XLEN{1'b0}}, ONE}) : acc;
        quot_fix = neg ? (~acc[XLEN-1:0] + ONE) : acc[XLEN-1:0];
        rem_fix  = neg ? (~acc[2*XLEN-1:XLEN] + ONE) : acc[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 fix_val = acc[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = acc_neg[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quot_fix;
            default:                fix_val = rem_fix;
        endcase
    end

    // Next-state and stall decode
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start && !flush) begin
                    state_nxt = special ? DONE : ITER;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ITER: begin
                stall = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = (counter == LAST) ? FIX : ITER;
                end
            end
            FIX: begin
                stall     = 1'b1;
                state_nxt = flush ? IDLE : DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign result_valid = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: operand latch, iteration, and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter <= {CW{1'b0}};
            op      <= 3'b000;
            neg     <= 1'b0;
            opnd    <= ZERO;
            acc     <= {(2*XLEN){1'b0}};
            result  <= ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op      <= funct_3;
                        neg     <= res_neg;
                        counter <= {CW{1'b0}};
                        if (special) begin
                            result <= special_val;
                        end else if (funct_3[2]) begin
                            acc  <= {ZERO, mag1};
                            opnd <= mag2;
                        end else begin
                            acc  <= {ZERO, mag2};
                            opnd <= mag1;
                        end
                    end
                end
                ITER: begin
                    if (!flush) begin
                        acc     <= op[2] ? div_next : mul_next;
                        counter <= counter + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                FIX: begin
                    if (!flush) begin
                        result <= fix_val;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, special cases,
// flush, mid-operation reset and back-to-back issue.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct_3 = 3'b000;
    logic [31:0] in1 = 32'h0;
    logic [31:0] in2 = 32'h0;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct_3(funct_3),
        .in1(in1), .in2(in2), .flush(flush), .stall(stall),
        .result(result), .result_valid(result_valid)
    );

    // Issue one op and measure stall cycles, valid pulses and the result (no checking here)
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int valids, output logic [31:0] res);
        stalls = 0;
        valids = 0;
        res = 32'h0;
        @(posedge clk); #1;
        start = 1'b1; funct_3 = f; in1 = a; in2 = b;
        for (int n = 0; n < 60 && valids == 0; n++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (result_valid) begin
                valids++;
                res = result;
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        if (result_valid) valids++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", result); end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        int s, v; logic [31:0] r;
        do_op(3'b000, 32'd7, 32'd6, s, v, r);
        checks++; if (s !== 34) begin failures++; $display("FAIL mul_stall_cycles: got %0d expected 34", s); end
        checks++; if (v !== 1) begin failures++; $display("FAIL mul_valid_pulses: got %0d expected 1", v); end
        checks++; if (r !== 32'd42) begin failures++; $display("FAIL mul_result: got %h expected 0000002a", r); end
    endtask

    task automatic test_mulh();
        int s, v; logic [31:0] r;
        do_op(3'b001, 32'hFFFFFFFF, 32'd2, s, v, r);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulh_result: got %h expected ffffffff", r); end
        checks++; if (s !== 34) begin failures++; $display("FAIL mulh_stall_cycles: got %0d expected 34", s); end
        do_op(3'b011, 32'hFFFFFFFF, 32'd2, s, v, r);
        checks++; if (r !== 32'h00000001) begin failures++; $display("FAIL mulhu_result: got %h expected 00000001", r); end
        do_op(3'b010, 32'hFFFFFFFF, 32'd2, s, v, r);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu_result: got %h expected ffffffff", r); end
        do_op(3'b011, 32'h80000001, 32'h00000010, s, v, r);
        checks++; if (r !== 32'h00000008) begin failures++; $display("FAIL mulhu_carry: got %h expected 00000008", r); end
    endtask

    task automatic test_div();
        int s, v; logic [31:0] r;
        do_op(3'b100, 32'hFFFFFFF9, 32'd2, s, v, r);
        checks++; if (r !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_result: got %h expected fffffffd", r); end
        checks++; if (s !== 34) begin failures++; $display("FAIL div_stall_cycles: got %0d expected 34", s); end
        do_op(3'b110, 32'hFFFFFFF9, 32'd2, s, v, r);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem_result: got %h expected ffffffff", r); end
        do_op(3'b101, 32'hFFFFFFFF, 32'd2, s, v, r);
        checks++; if (r !== 32'h7FFFFFFF) begin failures++; $display("FAIL divu_result: got %h expected 7fffffff", r); end
        do_op(3'b111, 32'd100, 32'd7, s, v, r);
        checks++; if (r !== 32'd2) begin failures++; $display("FAIL remu_result: got %h expected 00000002", r); end
    endtask

    task automatic test_special();
        logic [2:0]  f   [4];
        logic [31:0] a   [4];
        logic [31:0] b   [4];
        logic [31:0] exp [4];
        int s, v; logic [31:0] r;
        f[0] = 3'b101; a[0] = 32'd12;        b[0] = 32'h0;        exp[0] = 32'hFFFFFFFF;
        f[1] = 3'b110; a[1] = 32'd5;         b[1] = 32'h0;        exp[1] = 32'd5;
        f[2] = 3'b100; a[2] = 32'h80000000;  b[2] = 32'hFFFFFFFF; exp[2] = 32'h80000000;
        f[3] = 3'b110; a[3] = 32'h80000000;  b[3] = 32'hFFFFFFFF; exp[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            do_op(f[i], a[i], b[i], s, v, r);
            checks++; if (r !== exp[i]) begin failures++; $display("FAIL special%0d_result: got %h expected %h", i, r, exp[i]); end
            checks++; if (s !== 1) begin failures++; $display("FAIL special%0d_stall_cycles: got %0d expected 1", i, s); end
            checks++; if (v !== 1) begin failures++; $display("FAIL special%0d_valid_pulses: got %0d expected 1", i, v); end
        end
    endtask

    task automatic test_flush();
        int s, v, stray; logic [31:0] r;
        @(posedge clk); #1;
        start = 1'b1; funct_3 = 3'b100; in1 = 32'd1000; in2 = 32'd7;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b expected 0", stall); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", result_valid); end
        stray = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (result_valid || stall) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL flush_stray_activity: got %0d expected 0", stray); end
        do_op(3'b000, 32'd3, 32'd3, s, v, r);
        checks++; if (r !== 32'd9) begin failures++; $display("FAIL flush_then_mul: got %h expected 00000009", r); end
        checks++; if (s !== 34) begin failures++; $display("FAIL flush_then_mul_stall: got %0d expected 34", s); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1'b1; funct_3 = 3'b000; in1 = 32'd11; in2 = 32'd13;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midreset_stall: got %b expected 0", stall); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b expected 0", result_valid); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL midreset_result: got %h expected 00000000", result); end
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midreset_idle_stall: got %b expected 0", stall); end
    endtask

    task automatic test_back_to_back();
        int v, c1, c2; logic [31:0] r1, r2;
        v = 0; c1 = 0; c2 = 0; r1 = 32'h0; r2 = 32'h0;
        @(posedge clk); #1;
        start = 1'b1; funct_3 = 3'b000; in1 = 32'd5; in2 = 32'd4;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            if (result_valid) begin
                v++;
                if (v == 1) begin
                    r1 = result; c1 = n;
                    in1 = 32'd6; in2 = 32'd7;
                end else begin
                    r2 = result; c2 = n;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++; if (v !== 2) begin failures++; $display("FAIL b2b_valid_pulses: got %0d expected 2", v); end
        checks++; if (r1 !== 32'd20) begin failures++; $display("FAIL b2b_first_result: got %h expected 00000014", r1); end
        checks++; if (r2 !== 32'd42) begin failures++; $display("FAIL b2b_second_result: got %h expected 0000002a", r2); end
        checks++; if (c2 - c1 !== 35) begin failures++; $display("FAIL b2b_spacing: got %0d expected 35", c2 - c1); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
